fir_kernel_ctrl: RTL and testbench



---
 rtl/fir_kernel_ctrl_pkg.sv | 58 +++++
 rtl/fir_kernel_ctrl_btn_debounce.sv | 42 ++++
 rtl/fir_kernel_ctrl.sv | 125 ++++++++++++
 tb/tb_fir_kernel_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_kernel_ctrl_pkg.sv
// Shared definitions for the FIR kernel sequencer: kernel indices, FSM encoding,
// the 3x3 coefficient ROM and the per-kernel normalisation shift.
package fir_kernel_pkg;

  localparam int          N_TAPS     = 9;
  localparam logic [3:0]  LAST_ADDR  = 4'd8;

  localparam logic [1:0]  K_IDENTITY = 2'd0;
  localparam logic [1:0]  K_GAUSS    = 2'd1;
  localparam logic [1:0]  K_SHARPEN  = 2'd2;
  localparam logic [1:0]  K_LAPLACE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_VS,
    S_LOAD,
    S_COMMIT
  } ctrl_state_e;

  // Raster-order taps; the centre tap sits at address 4.
  function automatic logic signed [7:0] coef(input logic [1:0] kernel, input logic [3:0] addr);
    logic signed [7:0] c;
    c = 8'sd0;
    case (kernel)
      K_IDENTITY: c = (addr == 4'd4) ? 8'sd1 : 8'sd0;
      K_GAUSS: begin
        case (addr)
          4'd4:                   c = 8'sd4;
          4'd1, 4'd3, 4'd5, 4'd7: c = 8'sd2;
          4'd0, 4'd2, 4'd6, 4'd8: c = 8'sd1;
          default:                c = 8'sd0;
        endcase
      end
      K_SHARPEN: begin
        case (addr)
          4'd4:                   c = 8'sd5;
          4'd1, 4'd3, 4'd5, 4'd7: c = -8'sd1;
          default:                c = 8'sd0;
        endcase
      end
      K_LAPLACE: begin
        case (addr)
          4'd4:                                           c = 8'sd8;
          4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8: c = -8'sd1;
          default:                                        c = 8'sd0;
        endcase
      end
      default: c = 8'sd0;
    endcase
    return c;
  endfunction

  // Gaussian taps sum to 16, so it alone needs a post-MAC shift.
  function automatic logic [2:0] shift_of(input logic [1:0] kernel);
    return (kernel == K_GAUSS) ? 3'd4 : 3'd0;
  endfunction

endpackage

// File: rtl/fir_kernel_ctrl_btn_debounce.sv
// One-bit button conditioner: 2-FF synchronizer, stability counter and a
// single-cycle press pulse on the accepted rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1048576,
  parameter int DB_W            = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic [1:0]      sync_q;
  logic            level_q;
  logic [DB_W-1:0] cnt_q;
  logic            stable_done;

  assign stable_done = (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      press  <= 1'b0;
      // Any sample matching the accepted level restarts the stability window.
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (stable_done) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
        press   <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/fir_kernel_ctrl.sv
// Frame-synchronous kernel sequencer: collects debounced button requests and,
// on the next vsync, streams the chosen 3x3 kernel to the shadow bank then commits.
module fir_kernel_ctrl
  import fir_kernel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1048576,
  parameter int DB_W            = 21,
  parameter int COEF_W          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               bt_i,
  input  logic                     vs_i,
  output logic [1:0]               kernel_o,
  output logic                     bypass_o,
  output logic                     coef_we_o,
  output logic [3:0]               coef_addr_o,
  output logic signed [COEF_W-1:0] coef_data_o,
  output logic [2:0]               shift_o,
  output logic                     commit_o,
  output logic                     busy_o
);

  logic [2:0]  press;
  logic        req_next, req_prev, req_byp;
  logic        vs_q, vs_rise;
  ctrl_state_e state, state_d;
  logic        snap;

  logic [1:0]  tgt_kernel;
  logic        tgt_bypass;
  logic        pending, pending_load;
  logic [1:0]  work_kernel;
  logic        work_bypass;
  logic [3:0]  load_addr;
  logic [1:0]  kernel_q;
  logic        bypass_q;
  logic [2:0]  shift_q;

  for (genvar i = 0; i < 3; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_W           (DB_W)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .btn  (bt_i[i]),
      .press(press[i])
    );
  end

  // Simultaneous next/prev cancel each other out.
  assign req_next = press[0] & ~press[1];
  assign req_prev = press[1] & ~press[0];
  assign req_byp  = press[2];
  assign vs_rise  = vs_i & ~vs_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    snap    = 1'b0;
    case (state)
      S_IDLE:    if (pending) state_d = S_WAIT_VS;
      S_WAIT_VS: begin
        if (vs_rise) begin
          snap    = 1'b1;
          state_d = pending_load ? S_LOAD : S_COMMIT;
        end
      end
      S_LOAD:    if (load_addr == LAST_ADDR) state_d = S_COMMIT;
      S_COMMIT:  state_d = pending ? S_WAIT_VS : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Request capture; a request landing on the snapshot cycle survives the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q         <= 1'b0;
      tgt_kernel   <= K_IDENTITY;
      tgt_bypass   <= 1'b0;
      pending      <= 1'b1;
      pending_load <= 1'b1;
      load_addr    <= 4'd0;
      kernel_q     <= K_IDENTITY;
      bypass_q     <= 1'b0;
      shift_q      <= 3'd0;
    end else begin
      vs_q <= vs_i;
      if (req_next)      tgt_kernel <= tgt_kernel + 2'd1;
      else if (req_prev) tgt_kernel <= tgt_kernel - 2'd1;
      if (req_byp)       tgt_bypass <= ~tgt_bypass;
      pending      <= (pending & ~snap) | req_next | req_prev | req_byp;
      pending_load <= (pending_load & ~snap) | req_next | req_prev;
      load_addr    <= (state == S_LOAD) ? load_addr + 4'd1 : 4'd0;
      if (state == S_COMMIT) begin
        kernel_q <= work_kernel;
        bypass_q <= work_bypass;
        shift_q  <= shift_of(work_kernel);
      end
    end
  end

  // Work copy is frozen for the whole load, so late requests cannot tear it.
  always_ff @(posedge clk) begin
    if (snap) begin
      work_kernel <= tgt_kernel;
      work_bypass <= tgt_bypass;
    end
  end

  assign coef_we_o   = (state == S_LOAD);
  assign coef_addr_o = coef_we_o ? load_addr : 4'd0;
  assign coef_data_o = coef_we_o ? COEF_W'(coef(work_kernel, load_addr)) : '0;
  assign commit_o    = (state == S_COMMIT);
  assign kernel_o    = commit_o ? work_kernel : kernel_q;
  assign bypass_o    = commit_o ? work_bypass : bypass_q;
  assign shift_o     = commit_o ? shift_of(work_kernel) : shift_q;
  assign busy_o      = pending | (state != S_IDLE);

endmodule

// File: tb/tb_fir_kernel_ctrl.sv
// Scoreboard bench for fir_kernel_ctrl: directed scenarios plus random button
// sequences, checked against an abstract model of targets, vsync and ROM contents.
module tb_fir_kernel_ctrl;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        bt_i;
  logic              vs_i;
  logic [1:0]        kernel_o;
  logic              bypass_o;
  logic              coef_we_o;
  logic [3:0]        coef_addr_o;
  logic signed [7:0] coef_data_o;
  logic [2:0]        shift_o;
  logic              commit_o;
  logic              busy_o;

  fir_kernel_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .DB_W           (3),
    .COEF_W         (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bt_i       (bt_i),
    .vs_i       (vs_i),
    .kernel_o   (kernel_o),
    .bypass_o   (bypass_o),
    .coef_we_o  (coef_we_o),
    .coef_addr_o(coef_addr_o),
    .coef_data_o(coef_data_o),
    .shift_o    (shift_o),
    .commit_o   (commit_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_commit;
    int cyc;
    int addr;
    int data;
    int kernel;
    int shift;
    int bypass;
  } exp_t;

  exp_t sbq[$];
  int checks   = 0;
  int failures = 0;

  int coef_ref [4][9] = '{'{0, 0, 0, 0, 1, 0, 0, 0, 0},
                          '{1, 2, 1, 2, 4, 2, 1, 2, 1},
                          '{0, -1, 0, -1, 5, -1, 0, -1, 0},
                          '{-1, -1, -1, -1, 8, -1, -1, -1, -1}};
  int shift_ref [4] = '{0, 4, 0, 0};

  // Reference model: requested targets, pending flags, committed view.
  int m_tgt, m_byp, m_pend, m_pload, m_kern, m_bc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (coef_we_o || commit_o)) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: we=%0d commit=%0d at cycle %0d, expected no activity",
                 coef_we_o, commit_o, cyc);
      end else begin
        e = sbq.pop_front();
        chk("event_kind", int'(commit_o), int'(e.is_commit));
        chk("event_cycle", cyc, e.cyc);
        if (e.is_commit) begin
          chk("commit_kernel", kernel_o, e.kernel);
          chk("commit_shift", shift_o, e.shift);
          chk("commit_bypass", bypass_o, e.bypass);
          chk("commit_we_low", coef_we_o, 0);
        end else begin
          chk("wr_addr", coef_addr_o, e.addr);
          chk("wr_data", coef_data_o, e.data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    m_tgt = 0; m_byp = 0; m_pend = 1; m_pload = 1; m_kern = 0; m_bc = 0;
  endtask

  task automatic press(input logic [2:0] m, input int hold);
    bt_i = m;
    tick(hold);
    bt_i = 3'b000;
    tick(10);
    if (m[0] && !m[1]) begin
      m_tgt = (m_tgt + 1) % 4; m_pend = 1; m_pload = 1;
    end else if (m[1] && !m[0]) begin
      m_tgt = (m_tgt + 3) % 4; m_pend = 1; m_pload = 1;
    end
    if (m[2]) begin
      m_byp ^= 1; m_pend = 1;
    end
  endtask

  task automatic vsync();
    exp_t e;
    int   c;
    c = cyc;
    if (m_pend) begin
      if (m_pload) begin
        for (int i = 0; i < 9; i++) begin
          e = '{is_commit: 1'b0, cyc: c + 1 + i, addr: i, data: coef_ref[m_tgt][i],
                kernel: 0, shift: 0, bypass: 0};
          sbq.push_back(e);
        end
      end
      e = '{is_commit: 1'b1, cyc: (m_pload ? c + 10 : c + 1), addr: 0, data: 0,
            kernel: m_tgt, shift: shift_ref[m_tgt], bypass: m_byp};
      sbq.push_back(e);
      m_kern = m_tgt; m_bc = m_byp; m_pend = 0; m_pload = 0;
    end
    vs_i = 1'b1;
    tick(2);
    vs_i = 1'b0;
  endtask

  task automatic settle_check(input string tag);
    tick(14);
    chk({tag, "_kernel"}, kernel_o, m_kern);
    chk({tag, "_bypass"}, bypass_o, m_bc);
    chk({tag, "_shift"}, shift_o, shift_ref[m_kern]);
    chk({tag, "_busy"}, busy_o, m_pend);
  endtask

  logic [2:0] masks [6] = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b101, 3'b110};

  initial begin
    rst = 1'b1; bt_i = 3'b000; vs_i = 1'b0;
    tick(3);
    chk("rst_kernel", kernel_o, 0);
    chk("rst_bypass", bypass_o, 0);
    chk("rst_shift", shift_o, 0);
    chk("rst_we", coef_we_o, 0);
    chk("rst_addr", coef_addr_o, 0);
    chk("rst_data", coef_data_o, 0);
    chk("rst_commit", commit_o, 0);
    chk("rst_busy", busy_o, 1);
    rst = 1'b0;
    model_reset();
    tick(3);

    vsync();
    settle_check("powerup");

    press(3'b001, 10);
    vsync();
    settle_check("next_k1");

    press(3'b010, 10);
    vsync();
    settle_check("back_k0");

    // Short glitches on prev must not count; only the held press does.
    bt_i = 3'b010; tick(2); bt_i = 3'b000; tick(3);
    bt_i = 3'b010; tick(2); bt_i = 3'b000; tick(3);
    press(3'b010, 10);
    vsync();
    settle_check("wrap_k3");

    press(3'b100, 8);
    vsync();
    settle_check("bypass_only");

    press(3'b001, 8);
    press(3'b001, 8);
    vsync();
    press(3'b001, 8);
    chk("midload_busy", busy_o, 1);
    tick(5);
    vsync();
    settle_check("midload_k2");

    press(3'b001, 8);
    vsync();
    tick(3);
    chk("rstload_we5", coef_we_o, 1);
    chk("rstload_addr4", coef_addr_o, 4);
    rst = 1'b1;
    sbq.delete();
    tick(1);
    chk("rstload_we_off", coef_we_o, 0);
    chk("rstload_no_commit", commit_o, 0);
    chk("rstload_busy", busy_o, 1);
    chk("rstload_kernel", kernel_o, 0);
    tick(1);
    rst = 1'b0;
    model_reset();
    tick(5);
    vsync();
    settle_check("rstload_k0");

    for (int it = 0; it < 20; it++) begin
      int n;
      n = $urandom_range(0, 3);
      for (int p = 0; p < n; p++) press(masks[$urandom_range(0, 5)], $urandom_range(6, 12));
      vsync();
      settle_check("rand");
    end

    chk("sb_drain", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
